// File: rtl/aes_key_expand_multi_pkg.sv
// Shared types, key-length helpers and the AES S-box for the key-expansion engine.
package aes_keyexp_pkg;

    typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_BAD = 2'd3} key_len_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GEN = 2'd1, ST_DONE = 2'd2} state_e;

    localparam int MAX_WORDS = 60;
    localparam int WIDX_W    = $clog2(MAX_WORDS);
    typedef logic [WIDX_W-1:0] widx_t;

    function automatic logic [3:0] nk_of(key_len_e kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_e kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    function automatic widx_t total_words_of(key_len_e kl);
        case (kl)
            KL_128:  return widx_t'(44);
            KL_192:  return widx_t'(52);
            KL_256:  return widx_t'(60);
            default: return widx_t'(0);
        endcase
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

endpackage

// File: rtl/aes_key_expand_multi_if.sv
// Job/read-port bundle of the key-expansion engine; zeroize exists only with AES_KEYEXP_ZEROIZE_EN.
interface aes_key_expand_multi_if #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] key;
    logic                    busy;
    logic                    keys_valid;
    logic                    cfg_err;
    logic [3:0]              num_rounds;
    logic                    rk_rd;
    logic [RK_IDX_W-1:0]     rk_idx;
    logic [127:0]            rk_out;
    logic                    rk_out_valid;
    logic                    rk_err;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic                    zeroize;
`endif

    modport master (
`ifdef AES_KEYEXP_ZEROIZE_EN
        output zeroize,
`endif
        output start, key_len, key, rk_rd, rk_idx,
        input  busy, keys_valid, cfg_err, num_rounds, rk_out, rk_out_valid, rk_err
    );

    modport slave (
`ifdef AES_KEYEXP_ZEROIZE_EN
        input  zeroize,
`endif
        input  start, key_len, key, rk_rd, rk_idx,
        output busy, keys_valid, cfg_err, num_rounds, rk_out, rk_out_valid, rk_err
    );
endinterface

// File: rtl/aes_key_expand_multi_subword.sv
// Combinational AES SubWord: four parallel S-box lookups.
module aes_subword
    import aes_keyexp_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
    end
endmodule

// File: rtl/aes_key_expand_multi.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle, registered round-key read.
// Optional macro AES_KEYEXP_ZEROIZE_EN adds a zeroize input that wipes schedule and outputs.
module aes_key_expand_multi
    import aes_keyexp_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input logic clk,
    input logic reset,
    aes_key_expand_multi_if.slave kx
);
    localparam int NK_MAX = MAX_KEY_BITS / 32;
    localparam int DEPTH  = 4 * (NK_MAX + 7);

    state_e       state_q, state_d;
    logic [31:0]  sched [DEPTH];
    widx_t        i_q, nk_q, total_q;
    logic [2:0]   kmod_q, nkm1_q;
    logic [7:0]   rcon_q;
    logic [3:0]   nr_q;
    logic         cfg_err_q, rk_valid_q, rk_err_q;
    logic [127:0] rk_q;
    logic         zero_req;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign zero_req = kx.zeroize;
`else
    assign zero_req = 1'b0;
`endif

    key_len_e kl_in;
    logic     len_ok, start_ok, start_bad, last, rd_ok;
    widx_t    rd_base;
    assign kl_in     = key_len_e'(kx.key_len);
    assign len_ok    = (kl_in != KL_BAD) && (32 * int'(nk_of(kl_in)) <= MAX_KEY_BITS);
    assign start_ok  = kx.start && len_ok && !zero_req;
    assign start_bad = kx.start && !len_ok && !zero_req;
    assign last      = (i_q == total_q - widx_t'(1));
    assign rd_ok     = kx.rk_rd && (state_q == ST_DONE) && (int'(kx.rk_idx) <= int'(nr_q));
    assign rd_base   = widx_t'(4 * int'(kx.rk_idx));

    // Next schedule word: w[i] = w[i-Nk] ^ t, with t chosen by the position within the Nk group
    logic [31:0] w_prev, w_back, sub_in, sub_out, t, w_new;
    assign w_prev = sched[i_q - widx_t'(1)];
    assign w_back = sched[i_q - nk_q];
    assign sub_in = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (.din(sub_in), .dout(sub_out));

    always_comb begin
        t = w_prev;
        if (kmod_q == 3'd0)
            t = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == widx_t'(8) && kmod_q == 3'd4)
            t = sub_out;
        w_new = w_back ^ t;
    end

    always_comb begin
        state_d = state_q;
        if (zero_req)
            state_d = ST_IDLE;
        else if (start_ok)
            state_d = ST_GEN;
        else if (state_q == ST_GEN && last)
            state_d = ST_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q        <= '0;
            nk_q       <= '0;
            total_q    <= '0;
            kmod_q     <= '0;
            nkm1_q     <= '0;
            rcon_q     <= 8'h01;
            nr_q       <= '0;
            cfg_err_q  <= 1'b0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= start_bad;
            if (zero_req) begin
                nr_q <= '0;
            end else if (start_ok) begin
                nr_q    <= nr_of(kl_in);
                nk_q    <= widx_t'(nk_of(kl_in));
                nkm1_q  <= 3'(nk_of(kl_in) - 4'd1);
                total_q <= total_words_of(kl_in);
                i_q     <= widx_t'(nk_of(kl_in));
                kmod_q  <= '0;
                rcon_q  <= 8'h01;
            end else if (state_q == ST_GEN) begin
                i_q    <= i_q + widx_t'(1);
                kmod_q <= (kmod_q == nkm1_q) ? 3'd0 : kmod_q + 3'd1;
                if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
            end

            // Reads see the schedule as it stood before this edge
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            if (zero_req) begin
                rk_q <= '0;
            end else if (rd_ok) begin
                rk_q       <= {sched[rd_base], sched[rd_base + widx_t'(1)],
                               sched[rd_base + widx_t'(2)], sched[rd_base + widx_t'(3)]};
                rk_valid_q <= 1'b1;
            end else if (kx.rk_rd) begin
                rk_q     <= '0;
                rk_err_q <= 1'b1;
            end
        end
    end

    // Schedule store carries no reset; keys_valid gates every read
    always_ff @(posedge clk) begin
        if (zero_req) begin
            for (int k = 0; k < DEPTH; k++) sched[k] <= '0;
        end else if (start_ok) begin
            for (int j = 0; j < NK_MAX; j++)
                if (j < int'(nk_of(kl_in))) sched[j] <= kx.key[MAX_KEY_BITS-1-32*j -: 32];
        end else if (state_q == ST_GEN) begin
            sched[i_q] <= w_new;
        end
    end

    assign kx.busy         = (state_q == ST_GEN);
    assign kx.keys_valid   = (state_q == ST_DONE);
    assign kx.cfg_err      = cfg_err_q;
    assign kx.num_rounds   = nr_q;
    assign kx.rk_out       = rk_q;
    assign kx.rk_out_valid = rk_valid_q;
    assign kx.rk_err       = rk_err_q;
endmodule
